// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit. Steps FETCH/DECODE/EXE/MEM/WB,
// decodes datapath selects and enables from the state (plus Op/Funct in EXE
// and Zero in BRANCH). All outputs are held at 0 while rst_n is low.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] EXTOp,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic       InstrDone
);

  // ALU operation encodings
  localparam logic [1:0] ALUOP_ADDU = 2'b00;
  localparam logic [1:0] ALUOP_SUBU = 2'b01;
  localparam logic [1:0] ALUOP_OR   = 2'b10;
  localparam logic [1:0] ALUOP_MOV  = 2'b11;

  // State encodings (binary); 10..15 are unused and fall back to FETCH
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXE    = 4'd2;
  localparam logic [3:0] S_WB_ALU = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  // Opcodes / function codes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;

  logic [3:0] r_state;
  logic [3:0] w_next;

  logic w_rtype, w_fn_ok, w_ori, w_lui, w_lw, w_sw, w_beq, w_j;

  assign w_rtype = (Op == OP_RTYPE);
  assign w_fn_ok = (Funct == FN_ADDU) || (Funct == FN_SUBU) || (Funct == FN_OR);
  assign w_ori   = (Op == OP_ORI);
  assign w_lui   = (Op == OP_LUI);
  assign w_lw    = (Op == OP_LW);
  assign w_sw    = (Op == OP_SW);
  assign w_beq   = (Op == OP_BEQ);
  assign w_j     = (Op == OP_J);

  // Raw decoded outputs, before reset gating
  logic       w_pcwrite, w_irwrite, w_memread, w_memwrite, w_iord;
  logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca, w_illegal, w_done;
  logic [1:0] w_pcsource, w_alusrcb, w_extop, w_aluop;

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if ((w_rtype && w_fn_ok) || w_ori || w_lui) w_next = S_EXE;
        else if (w_lw || w_sw)                      w_next = S_ADDR;
        else if (w_beq)                             w_next = S_BRANCH;
        else if (w_j)                               w_next = S_JUMP;
        else                                        w_next = S_FETCH;
      end
      S_EXE:    w_next = S_WB_ALU;
      S_ADDR:   w_next = w_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = S_WB_MEM;
      default:  w_next = S_FETCH;
    endcase
  end

  // Per-state output decode; everything not named stays at its default
  always_comb begin
    w_pcwrite  = 1'b0;
    w_pcsource = 2'd0;
    w_irwrite  = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'd0;
    w_extop    = 2'd0;
    w_aluop    = ALUOP_ADDU;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'd1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        // branch target precomputed into ALUOut
        w_alusrcb = 2'd2;
        if (!((w_rtype && w_fn_ok) || w_ori || w_lui || w_lw || w_sw || w_beq || w_j)) begin
          w_illegal = 1'b1;
          w_done    = 1'b1;
        end
      end
      S_EXE: begin
        w_alusrca = 1'b1;
        if (w_ori) begin
          w_alusrcb = 2'd3;
          w_extop   = 2'd1;
          w_aluop   = ALUOP_OR;
        end else if (w_lui) begin
          w_alusrcb = 2'd3;
          w_extop   = 2'd2;
          w_aluop   = ALUOP_MOV;
        end else begin
          case (Funct)
            FN_SUBU: w_aluop = ALUOP_SUBU;
            FN_OR:   w_aluop = ALUOP_OR;
            default: w_aluop = ALUOP_ADDU;
          endcase
        end
      end
      S_WB_ALU: begin
        w_regwrite = 1'b1;
        w_regdst   = w_rtype;
        w_done     = 1'b1;
      end
      S_ADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'd3;
      end
      S_MEM_RD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_WB_MEM: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_done     = 1'b1;
      end
      S_MEM_WR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca  = 1'b1;
        w_aluop    = ALUOP_SUBU;
        w_pcsource = 2'd1;
        w_pcwrite  = Zero;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'd2;
        w_done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every output low, overriding the state decode
  assign PCWrite   = rst_n & w_pcwrite;
  assign PCSource  = rst_n ? w_pcsource : 2'd0;
  assign IRWrite   = rst_n & w_irwrite;
  assign MemRead   = rst_n & w_memread;
  assign MemWrite  = rst_n & w_memwrite;
  assign IorD      = rst_n & w_iord;
  assign RegWrite  = rst_n & w_regwrite;
  assign RegDst    = rst_n & w_regdst;
  assign MemtoReg  = rst_n & w_memtoreg;
  assign ALUSrcA   = rst_n & w_alusrca;
  assign ALUSrcB   = rst_n ? w_alusrcb : 2'd0;
  assign EXTOp     = rst_n ? w_extop : 2'd0;
  assign ALUOp     = rst_n ? w_aluop : ALUOP_ADDU;
  assign Illegal   = rst_n & w_illegal;
  assign InstrDone = rst_n & w_done;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a per-instruction microprogram model produces the
// expected cycle-by-cycle output vectors; randomized instruction streams are
// compared against it.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst;
  logic       MemtoReg, ALUSrcA, Illegal, InstrDone;
  logic [1:0] PCSource, ALUSrcB, EXTOp, ALUOp;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSource(PCSource), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .Illegal(Illegal), .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, EXTOp, ALUOp;
    logic       Illegal, InstrDone;
  } o_t;

  o_t exp_q[$];
  o_t obs_q[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic o_t sample();
    o_t s;
    s.PCWrite = PCWrite;   s.PCSource = PCSource; s.IRWrite = IRWrite;
    s.MemRead = MemRead;   s.MemWrite = MemWrite; s.IorD = IorD;
    s.RegWrite = RegWrite; s.RegDst = RegDst;     s.MemtoReg = MemtoReg;
    s.ALUSrcA = ALUSrcA;   s.ALUSrcB = ALUSrcB;   s.EXTOp = EXTOp;
    s.ALUOp = ALUOp;       s.Illegal = Illegal;   s.InstrDone = InstrDone;
    return s;
  endfunction

  // Expected output vector for every cycle of one instruction
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    o_t f, c;
    bit legal;
    exp_q.delete();
    f = '0; f.PCWrite = 1; f.IRWrite = 1; f.MemRead = 1; f.ALUSrcB = 2'd1;
    exp_q.push_back(f);
    legal = (op == 6'h00 && fn inside {6'h21, 6'h23, 6'h25}) ||
            (op inside {6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02});
    c = '0; c.ALUSrcB = 2'd2;
    if (!legal) begin
      c.Illegal = 1; c.InstrDone = 1;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    case (op)
      6'h00, 6'h0D, 6'h0F: begin
        c = '0; c.ALUSrcA = 1;
        if (op == 6'h0D)      begin c.ALUSrcB = 3; c.EXTOp = 1; c.ALUOp = 2'b10; end
        else if (op == 6'h0F) begin c.ALUSrcB = 3; c.EXTOp = 2; c.ALUOp = 2'b11; end
        else c.ALUOp = (fn == 6'h21) ? 2'b00 : (fn == 6'h23) ? 2'b01 : 2'b10;
        exp_q.push_back(c);
        c = '0; c.RegWrite = 1; c.RegDst = (op == 6'h00); c.InstrDone = 1;
        exp_q.push_back(c);
      end
      6'h23, 6'h2B: begin
        c = '0; c.ALUSrcA = 1; c.ALUSrcB = 3;
        exp_q.push_back(c);
        if (op == 6'h23) begin
          c = '0; c.MemRead = 1; c.IorD = 1; exp_q.push_back(c);
          c = '0; c.RegWrite = 1; c.MemtoReg = 1; c.InstrDone = 1; exp_q.push_back(c);
        end else begin
          c = '0; c.MemWrite = 1; c.IorD = 1; c.InstrDone = 1; exp_q.push_back(c);
        end
      end
      6'h04: begin
        c = '0; c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCSource = 1; c.PCWrite = z; c.InstrDone = 1;
        exp_q.push_back(c);
      end
      default: begin
        c = '0; c.PCWrite = 1; c.PCSource = 2; c.InstrDone = 1;
        exp_q.push_back(c);
      end
    endcase
  endfunction

  // Entered just after the edge that starts FETCH; collects one vector per
  // cycle until InstrDone (bounded), and leaves just after the next FETCH edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit rz);
    obs_q.delete();
    Op = op; Funct = fn; Zero = rz ? 1'($urandom % 2) : z;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      if (InstrDone === 1'b1) break;
      @(posedge clk); #1;
      if (rz) Zero = 1'($urandom % 2);
    end
    @(posedge clk); #1;
  endtask

  logic [5:0] legal_ops [7] = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
  logic [5:0] rfns [3] = '{6'h21, 6'h23, 6'h25};

  task automatic test_reset();
    rst_n = 0; Op = 6'($urandom); Funct = 6'($urandom); Zero = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (sample() !== o_t'(0)) $display("FAIL reset_outputs got %h want %h", sample(), o_t'(0));
    else n_pass++;
    @(posedge clk); #1; rst_n = 1;
    model(6'h02, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL reset_first_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL reset_first cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // Each legal class at least once, with Zero toggling randomly off-branch
  task automatic test_directed();
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h02};
    logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h25, 6'h3F, 6'h00, 6'h11, 6'h22, 6'h00, 6'h00, 6'h00};
    logic       zs  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int k = 0; k < 10; k++) begin
      model(ops[k], fns[k], zs[k]);
      run_instr(ops[k], fns[k], zs[k], ops[k] != 6'h04);
      n_chk++;
      if (obs_q.size() != exp_q.size()) $display("FAIL dir%0d_len op=%h got %0d want %0d", k, ops[k], obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL dir%0d op=%h cyc%0d got %h want %h", k, ops[k], i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3] = '{6'h3F, 6'h00, 6'h01};
    logic [5:0] fns [3] = '{6'h21, 6'h00, 6'h25};
    for (int k = 0; k < 3; k++) begin
      model(ops[k], fns[k], 1'b1);
      run_instr(ops[k], fns[k], 1'b1, 1'b1);
      n_chk++;
      if (obs_q.size() != exp_q.size()) $display("FAIL ill%0d_len got %0d want %0d", k, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL ill%0d cyc%0d got %h want %h", k, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic z;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom % 4 == 0) ? 6'($urandom) : legal_ops[$urandom % 7];
      fn = ($urandom % 5 == 0) ? 6'($urandom) : rfns[$urandom % 3];
      z  = 1'($urandom % 2);
      model(op, fn, z);
      run_instr(op, fn, z, op != 6'h04);
      n_chk++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_len op=%h fn=%h got %0d want %0d", k, op, fn, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rnd%0d op=%h fn=%h cyc%0d got %h want %h", k, op, fn, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  // Reset lands in the MEM_WR cycle of a sw; the following instruction must
  // start cleanly from FETCH.
  task automatic test_reset_mid();
    Op = 6'h2B; Funct = 6'h00; Zero = 0;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++;
    if (MemWrite !== 1'b1) $display("FAIL midrst_memwr_pre got %b want 1", MemWrite);
    else n_pass++;
    rst_n = 0;
    @(negedge clk);
    n_chk++;
    if (sample() !== o_t'(0)) $display("FAIL midrst_outputs got %h want %h", sample(), o_t'(0));
    else n_pass++;
    @(posedge clk); #1; rst_n = 1;
    model(6'h00, 6'h23, 1'b0);
    run_instr(6'h00, 6'h23, 1'b0, 1'b1);
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL midrst_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_after cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 0; Op = 0; Funct = 0; Zero = 0;
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
